// File: rtl/crc_check_pkg.sv
// crc_check_pkg: shared tag type, FSM states and saturating-increment helper for the CRC check stage
package crc_check_pkg;

    localparam int c_tag_width = 8;

    typedef struct packed {
        logic                   valid;
        logic [c_tag_width-1:0] expected;
    } tag_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v == max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/crc_tag_delay.sv
// crc_tag_delay: p_latency-deep valid/payload shift register for pipeline-aligned sideband
module crc_tag_delay #(
    parameter int p_width   = 8,
    parameter int p_latency = 32
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [p_width-1:0] in_data,
    output logic               out_valid,
    output logic [p_width-1:0] out_data
);

    logic [p_latency-1:0] vld;
    logic [p_width-1:0]   dat [p_latency];

    // Valid chain: reset or flush drops every in-flight entry, including the one arriving now
    always_ff @(posedge clk) begin
        vld <= (!rstN || flush) ? '0 : p_latency'({vld, in_valid});
    end

    // Payload chain shifts freely; it only matters alongside its valid bit
    always_ff @(posedge clk) begin
        dat[0] <= in_data;
        for (int i = 1; i < p_latency; i++) dat[i] <= dat[i-1];
    end

    assign out_valid = vld[p_latency-1];
    assign out_data  = dat[p_latency-1];

endmodule

// File: rtl/crc_check_stage.sv
// crc_check_stage: compares generator output against latency-aligned expected CRC tags, counts pass/fail
// Optional sticky first-failure capture is enabled by defining CRC_CHECK_STICKY_EN.
module crc_check_stage
    import crc_check_pkg::*;
#(
    parameter int p_width     = 8,
    parameter int p_latency   = 32,
    parameter int p_cnt_width = 16
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   inp_valid,
    input  logic [p_width-1:0]     inp_expected,
    input  logic [p_width-1:0]     crc_data,
    input  logic                   clear,
    output logic                   outp_valid,
    output logic                   outp_match,
    output logic [p_width-1:0]     outp_crc,
    output logic [p_cnt_width-1:0] pass_cnt,
    output logic [p_cnt_width-1:0] fail_cnt,
    output logic                   busy
`ifdef CRC_CHECK_STICKY_EN
    ,
    output logic                   first_fail,
    output logic [p_width-1:0]     first_fail_crc,
    output logic [p_cnt_width-1:0] first_fail_idx
`endif
);

    localparam int c_fw = $clog2(p_latency + 1);
    localparam logic [p_cnt_width-1:0] c_cnt_max = '1;

    typedef struct packed {
        logic               valid;
        logic [p_width-1:0] expected;
    } tag_w_t;

    tag_w_t          tag_in;
    logic            tail_valid;
    logic [p_width-1:0] tail_exp;
    logic            hit;
    logic [c_fw-1:0] inflight, inflight_nxt;
    state_t          state, state_nxt;

    assign tag_in = '{valid: inp_valid, expected: inp_expected};

    crc_tag_delay #(
        .p_width  (p_width),
        .p_latency(p_latency)
    ) u_tags (
        .clk      (clk),
        .rstN     (rstN),
        .flush    (clear),
        .in_valid (tag_in.valid),
        .in_data  (tag_in.expected),
        .out_valid(tail_valid),
        .out_data (tail_exp)
    );

    // Tail compare, in-flight bookkeeping and next FSM state; IDLE never holds tags
    always_comb begin
        hit          = (crc_data == tail_exp);
        inflight_nxt = inflight + c_fw'(inp_valid) - c_fw'(tail_valid);
        state_nxt    = inp_valid ? RUN : (state != IDLE && inflight_nxt != '0) ? DRAIN : IDLE;
    end

    // Registered result, saturating counters and FSM; clear keeps the last result visible
    always_ff @(posedge clk) begin
        if (!rstN) begin
            outp_valid <= 1'b0;
            outp_match <= 1'b0;
            outp_crc   <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            inflight   <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
        end else if (clear) begin
            outp_valid <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            inflight   <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
        end else begin
            outp_valid <= tail_valid;
            if (tail_valid) begin
                outp_match <= hit;
                outp_crc   <= crc_data;
            end
            if (tail_valid && hit)
                pass_cnt <= p_cnt_width'(sat_inc(32'(pass_cnt), 32'(c_cnt_max)));
            if (tail_valid && !hit)
                fail_cnt <= p_cnt_width'(sat_inc(32'(fail_cnt), 32'(c_cnt_max)));
            inflight <= inflight_nxt;
            state    <= state_nxt;
            busy     <= (state_nxt != IDLE);
        end
    end

`ifdef CRC_CHECK_STICKY_EN
    // First mismatch since reset/clear is captured once and frozen
    always_ff @(posedge clk) begin
        if (!rstN || clear) begin
            first_fail     <= 1'b0;
            first_fail_crc <= '0;
            first_fail_idx <= '0;
        end else if (tail_valid && !hit && !first_fail) begin
            first_fail     <= 1'b1;
            first_fail_crc <= crc_data;
            first_fail_idx <= pass_cnt + fail_cnt;
        end
    end
`endif

endmodule

// File: doc/crc_check_stage.md
Name: crc_check_stage

Overview:
- Downstream stage of the pipelined CRC generator. Consumes its outp_data and compares each result against an expected CRC.
- The expected CRC is tagged at issue time and delayed through a tag pipeline matched to the generator latency.
- Produces per-word match/mismatch results and saturating pass/fail counters for on-chip self-check and FPGA bring-up.

Parameters:
- p_width, 8, CRC/data width; must equal the generator's p_width.
- p_latency, 32, generator pipeline depth in clk cycles from inp_data to outp_data (equals generator p_len); legal range 1..256.
- p_cnt_width, 16, width of pass/fail counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstN  in  1  synchronous active-low reset.
- inp_valid  in  1  asserted in the cycle a new word is applied to the generator input.
- inp_expected  in  p_width  expected CRC for that word, sampled with inp_valid.
- crc_data  in  p_width  generator outp_data.
- clear  in  1  synchronous flush of in-flight tags and counters.
- outp_valid  out  1  one-cycle strobe, result available.
- outp_match  out  1  1 = crc_data equalled tagged expected.
- outp_crc  out  p_width  captured crc_data for this result.
- pass_cnt  out  p_cnt_width  saturating count of matches.
- fail_cnt  out  p_cnt_width  saturating count of mismatches.
- busy  out  1  at least one tag in flight.

Behaviour:
- Reset (rstN=0 at posedge):
  - All outputs are 0.
  - Tag pipeline valids are cleared; FSM goes to IDLE.
- Tag pipeline:
  - p_latency stages, each holding {valid, expected}.
  - Stage 0 loads {inp_valid, inp_expected} every cycle.
  - Tail aligns with crc_data for the same word.
- Compare:
  - When the tail is valid, crc_data is compared bitwise to the tail expected.
  - The result is registered, so outp_valid rises exactly p_latency+1 cycles after inp_valid.
  - outp_match and outp_crc hold their values until the next outp_valid; outp_valid is a single-cycle strobe.
- Throughput: one word per cycle, back-to-back inp_valid fully supported, no backpressure.
- FSM:
  - IDLE -> RUN on inp_valid.
  - RUN -> DRAIN when inp_valid=0 and tags remain in flight.
  - DRAIN -> RUN on inp_valid.
  - DRAIN -> IDLE when the in-flight count reaches 0.
  - Any state -> IDLE on clear.
  - busy = (state != IDLE).
- In-flight counter: width clog2(p_latency+1).
  - +1 on accepted inp_valid; -1 when the tail valid is consumed; both in the same cycle leave it unchanged.
- Counters:
  - pass_cnt increments on a registered match, fail_cnt on a registered mismatch.
  - Both saturate at all-ones with no wrap.
- clear:
  - Zeroes all tag valids, the in-flight count, pass_cnt and fail_cnt.
  - Forces outp_valid=0 next cycle; outp_match and outp_crc keep their last values.
  - clear with inp_valid in the same cycle: clear wins and the word is dropped (not tagged).
  - clear in the same cycle as a tail compare: that result is discarded and counters read 0.
- Reset mid-operation: identical to clear, and additionally clears outp_match and outp_crc.
- crc_data is ignored whenever the tail tag is invalid, so X/garbage on it during reset or idle produces no output.

Optional Feature:
- Macro CRC_CHECK_STICKY_EN.
- Defined:
  - Adds outputs first_fail (1), first_fail_crc (p_width) and first_fail_idx (p_cnt_width).
  - On the first mismatch after reset/clear, these capture the crc_data value and the count of results seen before it (pass_cnt+fail_cnt).
  - They stay frozen until clear or reset.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package crc_check_pkg holds:
  - typedef tag_t {logic valid; logic [p_width-1:0] expected} (parameterized via a localparam default of 8, overridden in-module);
  - enum state_t {IDLE, RUN, DRAIN};
  - function sat_inc.
- Sub-module crc_tag_delay: parameterized p_latency-deep shift register with synchronous active-low reset and flush input, reusable for other pipeline-aligned sideband.

Test Plan:
- Reset for 10 cycles, then a single inp_valid with inp_expected=0x5A while the bench drives crc_data=0x5A at cycle +32 -> outp_valid at cycle +33, outp_match=1, pass_cnt=1, busy drops one cycle after the compare.
- 64 back-to-back words, bench reference model CRC (poly 0x31) with word 17 corrupted (xor 0x01) -> 64 outp_valid strobes, one mismatch at index 17, pass_cnt=63, fail_cnt=1.
- clear asserted 10 cycles after 5 words were issued, together with a new inp_valid -> no outp_valid afterwards, counters 0, busy=0 the cycle after clear.
- rstN pulled low mid-stream with 20 tags in flight -> all outputs 0 next cycle and no stray outp_valid after release, even with crc_data=X.
- p_cnt_width=4, 20 matching words -> pass_cnt saturates at 0xF and stays there.
- With CRC_CHECK_STICKY_EN, mismatches at indices 3 and 9 -> first_fail=1, first_fail_idx=3, first_fail_crc = word-3 data; index 9 does not overwrite; cleared by clear.
